// File: rtl/fetch_unit_if.sv
// Bus bundle for fetch_unit: instruction-memory request/response, redirect
// input and the decode-side valid/ready output.
interface fetch_unit_if;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [31:0] imem_req_addr;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_instr;
  logic [31:0] out_pc;
  logic [6:0]  out_opcode;
  logic [2:0]  out_funct3;

  modport master (
    output imem_req_valid, imem_req_addr, out_valid, out_instr, out_pc,
           out_opcode, out_funct3,
    input  imem_req_ready, imem_rsp_valid, imem_rsp_data, redirect_valid,
           redirect_pc, out_ready
  );

  modport slave (
    input  imem_req_valid, imem_req_addr, out_valid, out_instr, out_pc,
           out_opcode, out_funct3,
    output imem_req_ready, imem_rsp_valid, imem_rsp_data, redirect_valid,
           redirect_pc, out_ready
  );
endinterface

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: owns the PC, issues credit-limited word fetches,
// buffers in-order responses with their PCs and drops stale ones after a redirect.
module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int unsigned DEPTH    = 2
) (
  input logic          clk,
  input logic          rst,
  fetch_unit_if.master bus
);

  localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = $clog2(DEPTH + 1);
  localparam logic [CW:0] LIMIT = (CW+1)'(DEPTH);

  typedef logic [CW-1:0] cnt_t;

  logic [31:0]   pc;
  logic [31:0]   rsp_pc;
  cnt_t          inflight;
  cnt_t          stale;
  cnt_t          count;
  logic [PW-1:0] head;
  logic [PW-1:0] tail;
  logic [31:0]   q_pc    [DEPTH];
  logic [31:0]   q_instr [DEPTH];

  logic        req_fire;
  logic        push;
  logic        pop;
  logic [31:0] redir_aligned;

  // Credit covers both outstanding and buffered words, so a response always has a slot.
  assign bus.imem_req_valid = !rst && !bus.redirect_valid &&
                              (({1'b0, inflight} + {1'b0, count}) < LIMIT);
  assign bus.imem_req_addr  = pc;
  assign bus.out_valid      = !rst && (count != '0);
  assign bus.out_instr      = q_instr[head];
  assign bus.out_pc         = q_pc[head];
  assign bus.out_opcode     = q_instr[head][6:0];
  assign bus.out_funct3     = q_instr[head][14:12];

  assign req_fire      = bus.imem_req_valid && bus.imem_req_ready;
  assign pop           = bus.out_valid && bus.out_ready;
  assign push          = bus.imem_rsp_valid && (stale == '0) && !bus.redirect_valid;
  assign redir_aligned = bus.redirect_pc & ~32'h3;

  always_ff @(posedge clk) begin
    if (rst) begin
      pc       <= RESET_PC;
      rsp_pc   <= RESET_PC;
      inflight <= '0;
      stale    <= '0;
      count    <= '0;
      head     <= '0;
      tail     <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
        q_pc[i]    <= '0;
        q_instr[i] <= '0;
      end
    end else if (bus.redirect_valid) begin
      // Every response still owed after this cycle belongs to the old path.
      pc       <= redir_aligned;
      rsp_pc   <= redir_aligned;
      inflight <= inflight - cnt_t'(bus.imem_rsp_valid);
      stale    <= inflight - cnt_t'(bus.imem_rsp_valid);
      count    <= '0;
      head     <= '0;
      tail     <= '0;
    end else begin
      if (req_fire)
        pc <= pc + 32'd4;
      inflight <= inflight + cnt_t'(req_fire) - cnt_t'(bus.imem_rsp_valid);
      if (bus.imem_rsp_valid && (stale != '0))
        stale <= stale - 1'b1;
      if (push) begin
        q_pc[tail]    <= rsp_pc;
        q_instr[tail] <= bus.imem_rsp_data;
        tail          <= tail + 1'b1;
        rsp_pc        <= rsp_pc + 32'd4;
      end
      if (pop)
        head <= head + 1'b1;
      count <= count + cnt_t'(push) - cnt_t'(pop);
    end
  end

endmodule
